// File: rtl/control_unit.sv
// control_unit: sequencer for the 8-bit CPU datapath.
// Runs FETCH / DECODE / EXECUTE / (WB for ALU ops) per instruction until HLT
// is executed or Run is dropped at an instruction boundary.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-high reset, forces IDLE
//   Run          in   start/continue request, sampled in IDLE and at instruction end
//   IRCU[3:0]    in   opcode from datapath IR, sampled in DECODE
//   A_select     out  0 = A from InputA, 1 = A from ANS
//   B_select     out  0 = B from InputB, 1 = B from ANS
//   Aload/Bload  out  register A/B load enables
//   mode[3:0]    out  ALU operation code
//   IRload       out  IR load enable
//   PCload       out  PC load enable
//   ANSload      out  ANS register load enable
//   JSM[1:0]     out  PC next select: 00 = PC+1, 01 = jump target, 10 = hold
//   select_mode  out  output mux select (registered): 00 A, 01 B, 10 ANS
//   Halted       out  high while in HALT
//   icount[7:0]  out  retired-instruction counter, wraps
module control_unit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [3:0] IRCU,
    output logic       A_select,
    output logic       B_select,
    output logic       Aload,
    output logic       Bload,
    output logic [3:0] mode,
    output logic       IRload,
    output logic       PCload,
    output logic       ANSload,
    output logic [1:0] JSM,
    output logic [1:0] select_mode,
    output logic       Halted,
    output logic [7:0] icount
);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExecute, StWb, StHalt} state_e;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpLda  = 4'h1;
    localparam logic [3:0] OpLdb  = 4'h2;
    localparam logic [3:0] OpMova = 4'h3;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpOuta = 4'hD;
    localparam logic [3:0] OpOutb = 4'hE;
    localparam logic [3:0] OpHlt  = 4'hF;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] icount_q, icount_d;
    logic       op_is_alu;

    // ALU opcodes occupy 0100..1011; their mode is the offset from 0100.
    assign op_is_alu = (op_q >= 4'h4) && (op_q <= 4'hB);

    // State register plus the opcode, output-select and counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            op_q     <= 4'h0;
            sel_q    <= 2'b00;
            icount_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            icount_q <= icount_d;
        end
    end

    // Next-state logic. select_mode changes on entry into the state that owns
    // the effect, so OUTA/OUTB are decided from IRCU while still in DECODE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sel_d    = sel_q;
        icount_d = icount_q;
        unique case (state_q)
            StIdle: begin
                if (Run) state_d = StFetch;
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                op_d    = IRCU;
                state_d = StExecute;
                if (IRCU == OpOuta) begin
                    sel_d = 2'b00;
                end else if (IRCU == OpOutb) begin
                    sel_d = 2'b01;
                end
            end
            StExecute: begin
                if (op_q == OpHlt) begin
                    state_d  = StHalt;
                    icount_d = icount_q + 8'd1;
                end else if (op_is_alu) begin
                    state_d = StWb;
                    sel_d   = 2'b10;
                end else begin
                    icount_d = icount_q + 8'd1;
                    state_d  = Run ? StFetch : StIdle;
                end
            end
            StWb: begin
                icount_d = icount_q + 8'd1;
                state_d  = Run ? StFetch : StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs from state and latched opcode.
    always_comb begin
        A_select = 1'b0;
        B_select = 1'b0;
        Aload    = 1'b0;
        Bload    = 1'b0;
        mode     = 4'h0;
        IRload   = 1'b0;
        PCload   = 1'b0;
        ANSload  = 1'b0;
        JSM      = 2'b00;
        Halted   = 1'b0;
        unique case (state_q)
            StFetch: begin
                IRload = 1'b1;
                JSM    = 2'b10;
            end
            StDecode: begin
                JSM = 2'b10;
            end
            StExecute: begin
                // Default PC advance; JMP retargets it and HLT suppresses it.
                PCload = 1'b1;
                case (op_q)
                    OpNop: ;
                    OpLda: Aload = 1'b1;
                    OpLdb: Bload = 1'b1;
                    OpMova: begin
                        Aload    = 1'b1;
                        A_select = 1'b1;
                    end
                    OpJmp: JSM = 2'b01;
                    OpHlt: PCload = 1'b0;
                    default: begin
                        if (op_is_alu) begin
                            mode    = op_q - 4'h4;
                            ANSload = 1'b1;
                        end
                    end
                endcase
            end
            StWb: begin
                mode = op_q - 4'h4;
            end
            StHalt: begin
                Halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign select_mode = sel_q;
    assign icount      = icount_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level model (position within the
// current instruction plus latched opcode) is compared against every DUT
// output on each falling clock edge; directed literal checks pin key cycles.
module tb_control_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic [3:0] IRCU;
    logic       A_select, B_select, Aload, Bload, IRload, PCload, ANSload, Halted;
    logic [3:0] mode;
    logic [1:0] JSM, select_mode;
    logic [7:0] icount;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b1;

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .IRCU       (IRCU),
        .A_select   (A_select),
        .B_select   (B_select),
        .Aload      (Aload),
        .Bload      (Bload),
        .mode       (mode),
        .IRload     (IRload),
        .PCload     (PCload),
        .ANSload    (ANSload),
        .JSM        (JSM),
        .select_mode(select_mode),
        .Halted     (Halted),
        .icount     (icount)
    );

    always #5 Clk = ~Clk;

    logic [23:0] dut_vec;
    assign dut_vec = {A_select, B_select, Aload, Bload, mode, IRload, PCload, ANSload,
                      JSM, select_mode, Halted, icount};

    // Model: busy/halt flags, step 0..3 within the instruction, opcode.
    bit         m_busy = 1'b0;
    bit         m_halt = 1'b0;
    int         m_step = 0;
    logic [3:0] m_op   = 4'h0;
    logic [1:0] m_sel  = 2'b00;
    logic [7:0] m_cnt  = 8'h00;

    function automatic bit is_alu(input logic [3:0] op);
        return (op >= 4'd4) && (op <= 4'd11);
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_busy <= 1'b0;
            m_halt <= 1'b0;
            m_step <= 0;
            m_op   <= 4'h0;
            m_sel  <= 2'b00;
            m_cnt  <= 8'h00;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (!m_busy) begin
            if (Run) begin
                m_busy <= 1'b1;
                m_step <= 0;
            end
        end else if (m_step == 0) begin
            m_step <= 1;
        end else if (m_step == 1) begin
            m_op   <= IRCU;
            m_step <= 2;
            if (IRCU == 4'd13) m_sel <= 2'b00;
            else if (IRCU == 4'd14) m_sel <= 2'b01;
        end else if (m_op == 4'd15) begin
            m_halt <= 1'b1;
            m_busy <= 1'b0;
            m_cnt  <= m_cnt + 8'd1;
        end else if (m_step == 2 && is_alu(m_op)) begin
            m_step <= 3;
            m_sel  <= 2'b10;
        end else begin
            m_cnt  <= m_cnt + 8'd1;
            m_step <= 0;
            m_busy <= Run;
        end
    end

    function automatic logic [23:0] model_vec(input bit busy, input bit halt, input int step,
                                              input logic [3:0] op, input logic [1:0] sel,
                                              input logic [7:0] cnt);
        logic as, bs, al, bl, irl, pcl, ansl, hl;
        logic [3:0] md;
        logic [1:0] jsm;
        {as, bs, al, bl, irl, pcl, ansl, hl} = 8'h00;
        md  = 4'h0;
        jsm = 2'b00;
        if (halt) begin
            hl = 1'b1;
        end else if (busy) begin
            if (step == 0) begin
                irl = 1'b1;
                jsm = 2'b10;
            end else if (step == 1) begin
                jsm = 2'b10;
            end else if (step == 2) begin
                pcl = (op != 4'd15);
                if (op == 4'd12) jsm = 2'b01;
                al = (op == 4'd1) || (op == 4'd3);
                as = (op == 4'd3);
                bl = (op == 4'd2);
                if (is_alu(op)) begin
                    md   = op - 4'd4;
                    ansl = 1'b1;
                end
            end else begin
                md = op - 4'd4;
            end
        end
        return {as, bs, al, bl, md, irl, pcl, ansl, jsm, sel, hl, cnt};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            logic [23:0] exp_vec;
            exp_vec = model_vec(m_busy, m_halt, m_step, m_op, m_sel, m_cnt);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b1;
        IRCU  = 4'b0001;
        #100;
        chk("reset_outputs", {8'h0, dut_vec}, 32'h0);
        #2 Reset = 1'b0;

        // LDA then ALU 0101
        cyc();
        chk("release_irload", {31'h0, IRload}, 32'd1);
        cyc();                                      // DECODE samples 0001
        cyc();                                      // cycle 3: EXECUTE LDA
        chk("lda_exec", {Aload, A_select, PCload, JSM}, {27'h0, 5'b10100});
        IRCU = 4'b0101;
        cyc(3);                                     // cycle 6: EXECUTE ALU
        chk("alu_exec", {mode, ANSload}, {27'h0, 4'd1, 1'b1});
        cyc();                                      // cycle 7: WB
        chk("alu_wb", {mode, select_mode}, {26'h0, 4'd1, 2'b10});
        Run = 1'b0;
        cyc();
        chk("icount_two", {24'h0, icount}, 32'd2);

        // JMP, then back-to-back fetch
        IRCU = 4'b1100;
        Run  = 1'b1;
        cyc(3);
        chk("jmp_exec", {PCload, JSM, IRload}, {28'h0, 4'b1010});
        cyc();
        chk("jmp_next_fetch", {31'h0, IRload}, 32'd1);

        // LDB with Run dropped during DECODE
        IRCU = 4'b0010;
        cyc();
        Run = 1'b0;
        cyc();
        chk("ldb_exec", {Bload, PCload, JSM}, {28'h0, 4'b1100});
        cyc();
        chk("idle_enables", {Aload, Bload, IRload, PCload, ANSload, JSM, mode},
            32'h0);
        cyc();
        chk("idle_stays", {IRload, Halted}, 32'h0);
        Run = 1'b1;
        cyc();
        chk("resume_fetch", {31'h0, IRload}, 32'd1);

        // HLT
        IRCU = 4'b1111;
        cyc(3);
        chk("hlt_halted", {Halted, icount}, {23'h0, 1'b1, 8'd5});
        for (int i = 0; i < 10; i++) begin
            Run  = ~Run;
            IRCU = 4'(i);
            cyc();
            chk("halt_hold", {Halted, Aload, Bload, IRload, PCload, ANSload, icount},
                {18'h0, 6'b100000, 8'd5});
        end
        Reset = 1'b1;
        #2;
        chk("halt_reset", {Halted, icount}, 32'h0);
        Run   = 1'b1;
        IRCU  = 4'b0000;
        Reset = 1'b0;

        // 256 NOPs: icount wraps back to 0
        cyc(766);
        chk("icount_255", {24'h0, icount}, 32'd255);
        cyc(3);
        chk("icount_wrap", {24'h0, icount}, 32'd0);

        // OUTB then ALU 0111, reset during its EXECUTE
        IRCU = 4'b1110;
        cyc(2);
        chk("outb_sel", {30'h0, select_mode}, 32'd1);
        IRCU = 4'b0111;
        cyc(3);
        chk("alu3_exec", {mode, ANSload}, {27'h0, 4'd3, 1'b1});
        #2 Reset = 1'b1;
        #1;
        chk("async_reset", {ANSload, select_mode, icount, mode}, 32'h0);
        Run = 1'b0;
        #1 Reset = 1'b0;
        cyc(2);
        chk("post_reset_idle", {IRload, Halted, PCload}, 32'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
